// File: rtl/pwm_timer_multi.sv
`default_nettype none
// pwm_timer_multi - NCH independent PWM / one-shot / continuous timer channels sharing one prescaler tick.
// Revision 1.0
module pwm_timer_multi #(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int PW  = 16
) (
  input  logic              i_wb_clk,
  input  logic              i_wb_rst_n,
  input  logic [PW-1:0]     i_divisor,
  input  logic [NCH-1:0]    i_en,
  input  logic [2*NCH-1:0]  i_mode,
  input  logic [NCH-1:0]    i_pol,
  input  logic [NCH-1:0]    i_oe,
  input  logic [NCH-1:0]    i_sync_clr,
  input  logic [CW*NCH-1:0] i_period,
  input  logic [CW*NCH-1:0] i_dc,
  input  logic [NCH-1:0]    i_load,
  input  logic [NCH-1:0]    i_int_clr,
  output logic [NCH-1:0]    o_pwm,
  output logic [NCH-1:0]    o_int,
  output logic [CW*NCH-1:0] o_cnt
);

  localparam logic [1:0]    MODE_ONESHOT = 2'b01;
  localparam logic [1:0]    MODE_CONT    = 2'b10;
  localparam logic [PW-1:0] PRE_ONE      = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE      = {{(CW-1){1'b0}}, 1'b1};

  logic [PW-1:0]  pre;
  logic           tick;
  logic [NCH-1:0] raw_v;

  // Compare with >= so lowering the divisor below pre ticks at once instead of wrapping.
  assign tick = (pre >= i_divisor);

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_ONE;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [CW-1:0] per_a;
    logic [CW-1:0] dc_a;
    logic [CW-1:0] pe_m1;
    logic [1:0]    mode;
    logic          raw;
    logic          irq;
    logic          done;
    logic          lp;
    logic          en;
    logic          oneshot;
    logic          timer;
    logic          stopped;
    logic          run;
    logic          bnd;
    logic          irq_nxt;

    assign mode    = i_mode[2*k +: 2];
    assign en      = i_en[k];
    assign oneshot = (mode == MODE_ONESHOT);
    assign timer   = oneshot | (mode == MODE_CONT);
    assign pe_m1   = (per_a == '0) ? '0 : (per_a - CNT_ONE);
    assign stopped = oneshot & done;
    assign run     = tick & en;
    // An expired one-shot produces no further boundaries until its interrupt is cleared.
    assign bnd     = run & ~stopped & (cnt >= pe_m1);
    assign irq_nxt = (bnd & timer) | (irq & ~i_int_clr[k]);

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
        per_a <= '0;
        dc_a  <= '0;
      end else if (!en || (bnd && (lp || i_load[k]))) begin
        per_a <= i_period[k*CW +: CW];
        dc_a  <= i_dc[k*CW +: CW];
      end
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
        cnt  <= '0;
        raw  <= 1'b0;
        irq  <= 1'b0;
        done <= 1'b0;
        lp   <= 1'b0;
      end else if (i_sync_clr[k]) begin
        cnt  <= '0;
        raw  <= 1'b0;
        irq  <= 1'b0;
        done <= 1'b0;
        lp   <= 1'b0;
      end else begin
        if (en) begin
          lp <= bnd ? 1'b0 : (lp | i_load[k]);
        end
        irq <= irq_nxt;
        if (timer) begin
          raw <= irq_nxt;
        end else if (run) begin
          raw <= (cnt < dc_a);
        end
        if (bnd) begin
          cnt <= oneshot ? pe_m1 : '0;
          if (oneshot) begin
            done <= 1'b1;
          end
        end else if (oneshot && i_int_clr[k]) begin
          cnt  <= '0;
          done <= 1'b0;
        end else if (run && !stopped) begin
          cnt <= cnt + CNT_ONE;
        end
      end
    end

    assign raw_v[k]           = raw;
    assign o_int[k]           = irq;
    assign o_cnt[k*CW +: CW]  = cnt;
  end

  assign o_pwm = i_oe & (raw_v ^ i_pol);

endmodule
`default_nettype wire

// File: tb/tb_pwm_timer_multi.sv
`default_nettype none
// tb_pwm_timer_multi - directed and randomized checks of pwm_timer_multi against a behavioural model.
// Revision 1.0
module tb_pwm_timer_multi;

  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int PW  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PW-1:0]     divisor;
  logic [NCH-1:0]    en, pol, oe, sync_clr, load, int_clr;
  logic [2*NCH-1:0]  mode;
  logic [CW*NCH-1:0] period, dc;
  logic [NCH-1:0]    pwm, irq;
  logic [CW*NCH-1:0] cnt;

  int checks = 0;
  int errors = 0;

  pwm_timer_multi #(.NCH(NCH), .CW(CW), .PW(PW)) dut (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n),
    .i_divisor  (divisor),
    .i_en       (en),
    .i_mode     (mode),
    .i_pol      (pol),
    .i_oe       (oe),
    .i_sync_clr (sync_clr),
    .i_period   (period),
    .i_dc       (dc),
    .i_load     (load),
    .i_int_clr  (int_clr),
    .o_pwm      (pwm),
    .o_int      (irq),
    .o_cnt      (cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: per-channel integers updated once per rising edge from the spec's rules.
  int m_pre;
  int m_cnt[NCH];
  int m_per[NCH];
  int m_dc[NCH];
  bit m_lp[NCH], m_raw[NCH], m_int[NCH], m_done[NCH];

  task automatic model_reset();
    m_pre = 0;
    for (int k = 0; k < NCH; k++) begin
      m_cnt[k] = 0; m_per[k] = 0; m_dc[k] = 0;
      m_lp[k] = 0; m_raw[k] = 0; m_int[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic model_step();
    bit tick;
    tick  = (m_pre >= int'(divisor));
    m_pre = tick ? 0 : m_pre + 1;
    for (int k = 0; k < NCH; k++) begin
      int pe, new_per, new_dc;
      bit running, expired_os, boundary, take;
      logic [1:0] md;
      md         = mode[2*k +: 2];
      pe         = (m_per[k] == 0) ? 1 : m_per[k];
      running    = tick && en[k];
      expired_os = (md == 2'b01) && m_done[k];
      boundary   = running && !expired_os && (m_cnt[k] >= pe - 1);
      take       = !en[k] || (boundary && (m_lp[k] || load[k]));
      new_per    = take ? int'(period[k*CW +: CW]) : m_per[k];
      new_dc     = take ? int'(dc[k*CW +: CW]) : m_dc[k];
      if (sync_clr[k]) begin
        m_cnt[k] = 0; m_raw[k] = 0; m_int[k] = 0; m_done[k] = 0; m_lp[k] = 0;
      end else begin
        if (en[k]) m_lp[k] = boundary ? 1'b0 : (m_lp[k] | load[k]);
        case (md)
          2'b10: begin
            if (boundary) begin
              m_int[k] = 1; m_cnt[k] = 0;
            end else begin
              if (int_clr[k]) m_int[k] = 0;
              if (running) m_cnt[k]++;
            end
            m_raw[k] = m_int[k];
          end
          2'b01: begin
            if (boundary) begin
              m_int[k] = 1; m_done[k] = 1; m_cnt[k] = pe - 1;
            end else if (int_clr[k]) begin
              m_int[k] = 0; m_done[k] = 0; m_cnt[k] = 0;
            end else if (running && !m_done[k]) begin
              m_cnt[k]++;
            end
            m_raw[k] = m_int[k];
          end
          default: begin
            if (int_clr[k]) m_int[k] = 0;
            if (running) begin
              m_raw[k] = (m_cnt[k] < m_dc[k]);
              m_cnt[k] = boundary ? 0 : m_cnt[k] + 1;
            end
          end
        endcase
      end
      m_per[k] = new_per;
      m_dc[k]  = new_dc;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  function automatic logic [NCH-1:0] exp_pwm();
    logic [NCH-1:0] v;
    for (int k = 0; k < NCH; k++) v[k] = oe[k] & (m_raw[k] ^ pol[k]);
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_int();
    logic [NCH-1:0] v;
    for (int k = 0; k < NCH; k++) v[k] = m_int[k];
    return v;
  endfunction

  function automatic logic [CW*NCH-1:0] exp_cnt();
    logic [CW*NCH-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*CW +: CW] = CW'(m_cnt[k]);
    return v;
  endfunction

  task automatic cfg(input int k, input int md, input int p, input int d);
    mode[2*k +: 2]     = 2'(md);
    period[k*CW +: CW] = CW'(p);
    dc[k*CW +: CW]     = CW'(d);
  endtask

  // Program a channel while disabled and cleared, then enable it on the following negedge.
  task automatic settle_cfg(input int k, input int md, input int p, input int d);
    en[k] = 1'b0;
    cfg(k, md, p, d);
    sync_clr[k] = 1'b1;
    @(negedge clk);
    sync_clr[k] = 1'b0;
    en[k] = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; divisor = '0; en = '0; pol = '0; oe = '0; sync_clr = '0;
    load = '0; int_clr = '0; mode = '0; period = '0; dc = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    oe = '1;
    @(negedge clk);
    checks++; if (pwm !== '0) begin errors++; $display("FAIL reset_pwm got %b exp 0", pwm); end
    checks++; if (irq !== '0) begin errors++; $display("FAIL reset_int got %b exp 0", irq); end
    checks++; if (cnt !== '0) begin errors++; $display("FAIL reset_cnt got %h exp 0", cnt); end
  endtask

  task automatic test_pwm();
    int highs, want;
    divisor = '0; oe[0] = 1'b1; pol[0] = 1'b0;
    settle_cfg(0, 0, 10, 3);
    repeat (20) @(negedge clk);
    for (int ph = 0; ph < 3; ph++) begin
      if (ph == 1) pol[0] = 1'b1;
      if (ph == 2) oe[0] = 1'b0;
      highs = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (pwm[0]) highs++;
        checks++;
        if (pwm !== exp_pwm()) begin errors++; $display("FAIL pwm_model ph %0d got %b exp %b", ph, pwm, exp_pwm()); end
      end
      want = (ph == 0) ? 9 : (ph == 1) ? 21 : 0;
      checks++;
      if (highs != want) begin errors++; $display("FAIL pwm_duty ph %0d got %0d highs exp %0d", ph, highs, want); end
    end
    oe[0] = 1'b1; pol[0] = 1'b0;
  endtask

  task automatic test_timer();
    bit found;
    divisor = 16'd4; oe[1] = 1'b1; pol[1] = 1'b0;
    settle_cfg(1, 2, 5, 0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (irq[1]) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL cont_first_int got timeout exp rise"); end
    int_clr[1] = 1'b1;
    @(negedge clk);
    int_clr[1] = 1'b0;
    checks++; if (irq[1] !== 1'b0) begin errors++; $display("FAIL cont_int_clr got %b exp 0", irq[1]); end
    for (int i = 2; i <= 26; i++) begin
      @(negedge clk);
      checks++;
      if (irq[1] !== (i >= 25)) begin errors++; $display("FAIL cont_period n %0d got %b exp %b", i, irq[1], (i >= 25)); end
      checks++;
      if (irq !== exp_int() || cnt !== exp_cnt()) begin
        errors++; $display("FAIL cont_model got %b/%h exp %b/%h", irq, cnt, exp_int(), exp_cnt());
      end
      if (i == 24) int_clr[1] = 1'b1;
      if (i == 25) int_clr[1] = 1'b0;
    end
  endtask

  task automatic expect_oneshot_run();
    int want;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      want = (i < 8) ? i : 7;
      checks++;
      if (irq[2] !== (i == 8)) begin errors++; $display("FAIL os_int n %0d got %b exp %b", i, irq[2], (i == 8)); end
      checks++;
      if (cnt[2*CW +: CW] !== CW'(want)) begin errors++; $display("FAIL os_cnt n %0d got %0d exp %0d", i, cnt[2*CW +: CW], want); end
    end
  endtask

  task automatic test_oneshot();
    divisor = '0; oe[2] = 1'b1; pol[2] = 1'b0;
    settle_cfg(2, 1, 8, 0);
    expect_oneshot_run();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (cnt[2*CW +: CW] !== CW'(7) || irq[2] !== 1'b1) begin
        errors++; $display("FAIL os_hold got cnt %0d int %b exp 7/1", cnt[2*CW +: CW], irq[2]);
      end
    end
    int_clr[2] = 1'b1;
    @(negedge clk);
    int_clr[2] = 1'b0;
    checks++;
    if (cnt[2*CW +: CW] !== '0 || irq[2] !== 1'b0) begin
      errors++; $display("FAIL os_clr got cnt %0d int %b exp 0/0", cnt[2*CW +: CW], irq[2]);
    end
    expect_oneshot_run();
  endtask

  task automatic test_shadow();
    int highs, run, gap, n7, bad;
    bit found, rose, fell;
    bit s[60];
    divisor = '0;
    dc[0*CW +: CW] = CW'(7);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pwm[0]) highs++;
    end
    checks++; if (highs != 12) begin errors++; $display("FAIL shadow_noload got %0d highs exp 12", highs); end
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (cnt[0 +: CW] == CW'(4)) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL shadow_wait got timeout exp cnt 4"); end
    load[0] = 1'b1;
    @(negedge clk);
    load[0] = 1'b0;
    for (int i = 0; i < 60; i++) begin
      s[i] = pwm[0];
      checks++;
      if (pwm !== exp_pwm()) begin errors++; $display("FAIL shadow_model n %0d got %b exp %b", i, pwm, exp_pwm()); end
      @(negedge clk);
    end
    run = 0; gap = 0; n7 = 0; bad = 0; rose = 0; fell = 0;
    for (int i = 1; i < 60; i++) begin
      if (s[i] && !s[i-1]) begin
        if (fell && gap != 3 && gap != 7) bad++;
        run = 1; rose = 1;
      end else if (s[i] && s[i-1]) begin
        run++;
      end else if (!s[i] && s[i-1]) begin
        if (rose) begin
          if (run != 3 && run != 7) bad++;
          if (run == 7) n7++;
        end
        gap = 1; fell = 1;
      end else begin
        gap++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL shadow_glitch got %0d bad pulses exp 0", bad); end
    checks++; if (n7 < 5) begin errors++; $display("FAIL shadow_new_duty got %0d wide pulses exp >=5", n7); end
  endtask

  task automatic test_corners();
    int highs;
    divisor = '0;
    for (int c = 0; c < 2; c++) begin
      settle_cfg(0, 0, 10, (c == 0) ? 0 : 12);
      repeat (12) @(negedge clk);
      highs = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (pwm[0]) highs++;
      end
      checks++;
      if (highs != ((c == 0) ? 0 : 20)) begin errors++; $display("FAIL corner_dc c %0d got %0d highs exp %0d", c, highs, (c == 0) ? 0 : 20); end
    end
    oe[3] = 1'b1; pol[3] = 1'b0;
    settle_cfg(3, 2, 0, 0);
    int_clr[3] = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (cnt[3*CW +: CW] !== '0 || irq[3] !== 1'b1) begin
        errors++; $display("FAIL corner_per0 got cnt %0d int %b exp 0/1", cnt[3*CW +: CW], irq[3]);
      end
    end
    int_clr[3] = 1'b0;
  endtask

  task automatic test_sync_and_reset();
    logic [CW-1:0] prev0;
    divisor = '0; oe = '1; pol = '0;
    settle_cfg(0, 0, 10, 3);
    settle_cfg(1, 2, 5, 0);
    settle_cfg(2, 1, 8, 0);
    settle_cfg(3, 2, 50, 0);
    repeat (17) @(negedge clk);
    prev0 = cnt[0 +: CW];
    sync_clr[3] = 1'b1;
    @(negedge clk);
    sync_clr[3] = 1'b0;
    checks++;
    if (cnt[3*CW +: CW] !== '0 || irq[3] !== 1'b0 || pwm[3] !== 1'b0) begin
      errors++; $display("FAIL sync_clr_ch3 got cnt %0d int %b pwm %b exp 0/0/0", cnt[3*CW +: CW], irq[3], pwm[3]);
    end
    checks++;
    if (cnt[0 +: CW] !== CW'((int'(prev0) + 1) % 10)) begin
      errors++; $display("FAIL sync_clr_ch0 got %0d exp %0d", cnt[0 +: CW], (int'(prev0) + 1) % 10);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cnt !== exp_cnt()) begin errors++; $display("FAIL sync_model got %h exp %h", cnt, exp_cnt()); end
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cnt !== '0 || irq !== '0 || pwm !== '0) begin
      errors++; $display("FAIL async_reset got cnt %h int %b pwm %b exp 0", cnt, irq, pwm);
    end
    @(negedge clk);
    en = '0; load = '0; int_clr = '0; sync_clr = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      divisor = PW'($urandom_range(0, 3));
      for (int k = 0; k < NCH; k++) begin
        cfg(k, int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), int'($urandom_range(0, 14)));
        pol[k] = 1'($urandom_range(0, 1));
        oe[k]  = 1'($urandom_range(0, 1));
      end
      en = '0; sync_clr = '1;
      @(negedge clk);
      sync_clr = '0; en = '1;
      for (int i = 0; i < 150; i++) begin
        @(negedge clk);
        checks++; if (pwm !== exp_pwm()) begin errors++; $display("FAIL rand_pwm r %0d i %0d got %b exp %b", r, i, pwm, exp_pwm()); end
        checks++; if (irq !== exp_int()) begin errors++; $display("FAIL rand_int r %0d i %0d got %b exp %b", r, i, irq, exp_int()); end
        checks++; if (cnt !== exp_cnt()) begin errors++; $display("FAIL rand_cnt r %0d i %0d got %h exp %h", r, i, cnt, exp_cnt()); end
        load = '0; int_clr = '0; sync_clr = '0;
        for (int k = 0; k < NCH; k++) begin
          if ($urandom_range(0, 15) == 0) load[k] = 1'b1;
          if ($urandom_range(0, 7) == 0)  int_clr[k] = 1'b1;
          if ($urandom_range(0, 63) == 0) sync_clr[k] = 1'b1;
          if ($urandom_range(0, 31) == 0) en[k] = ~en[k];
          if ($urandom_range(0, 9) == 0) begin
            period[k*CW +: CW] = CW'($urandom_range(0, 12));
            dc[k*CW +: CW]     = CW'($urandom_range(0, 14));
          end
        end
        if ($urandom_range(0, 49) == 0) divisor = PW'($urandom_range(0, 3));
      end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_pwm();
    test_timer();
    test_oneshot();
    test_shadow();
    test_corners();
    test_sync_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
